// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control FSM.
// Steps each instruction through FETCH, DECODE, execute and writeback, and drives the
// enables and mux selects of a datapath that shares one ALU and one memory.
// Every memory access (fetch, load, store) lasts MEM_WAIT+1 cycles.
// Optional macro MCTRL_INSTRET_EN builds a 32-bit retired-instruction counter.
// Without it, instret_o is tied to 0.
module multicycle_control_fsm #(
    parameter int unsigned MEM_WAIT  = 1,
    parameter int unsigned IMM_SRC_W = 3,
    parameter int unsigned ALU_OP_W  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [6:0]           op_i,
    input  logic [2:0]           funct3_i,
    input  logic                 zero_i,
    output logic                 pc_write_o,
    output logic                 adr_src_o,
    output logic                 mem_write_o,
    output logic                 ir_write_o,
    output logic [1:0]           result_src_o,
    output logic [1:0]           alu_src_a_o,
    output logic [1:0]           alu_src_b_o,
    output logic [IMM_SRC_W-1:0] imm_src_o,
    output logic                 reg_write_o,
    output logic [ALU_OP_W-1:0]  alu_op_o,
    output logic                 instr_done_o,
    output logic                 illegal_o,
    output logic [31:0]          instret_o
);

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBeq,
        StJal,
        StJalrAddr,
        StJalrLink,
        StLui,
        StTrap
    } state_e;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpI     = 7'b0010011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;
    localparam logic [6:0] OpLui   = 7'b0110111;

    localparam logic [3:0] WaitLast = 4'(MEM_WAIT);

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       last;

    // Enables before the reset gate.
    logic pc_write, mem_write, ir_write, reg_write, instr_done;

    // Only funct3[0] distinguishes beq from bne.
    logic unused_funct3;
    assign unused_funct3 = ^funct3_i[2:1];

    assign last = (wait_q == WaitLast);

    // State and wait-counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StFetch;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic and Moore output decode.
    always_comb begin
        state_d      = state_q;
        wait_d       = '0;
        pc_write     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        instr_done   = 1'b0;
        adr_src_o    = 1'b0;
        result_src_o = 2'b00;
        alu_src_a_o  = 2'b00;
        alu_src_b_o  = 2'b00;
        alu_op_o     = '0;
        illegal_o    = 1'b0;

        unique case (state_q)
            StFetch: begin
                // ALU computes PC+4 while memory returns the instruction.
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
                if (last) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            StDecode: begin
                // Precompute oldPC+imm so branches and jal find their target in ALUOut.
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                case (op_i)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpR:             state_d = StExecR;
                    OpI:             state_d = StExecI;
                    OpBr:            state_d = StBeq;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalrAddr;
                    OpLui:           state_d = StLui;
                    default:         state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                state_d     = (op_i == OpLoad) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                adr_src_o = 1'b1;
                if (last) begin
                    state_d = StMemWb;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            StMemWb: begin
                result_src_o = 2'b01;
                reg_write    = 1'b1;
                instr_done   = 1'b1;
                state_d      = StFetch;
            end
            StMemWrite: begin
                adr_src_o = 1'b1;
                mem_write = 1'b1;
                if (last) begin
                    instr_done = 1'b1;
                    state_d    = StFetch;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            StExecR: begin
                alu_src_a_o = 2'b10;
                alu_op_o    = ALU_OP_W'(2'b10);
                state_d     = StAluWb;
            end
            StExecI: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                alu_op_o    = ALU_OP_W'(2'b10);
                state_d     = StAluWb;
            end
            StAluWb: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = StFetch;
            end
            StBeq: begin
                // funct3[0] inverts the sense of the zero flag for bne.
                alu_src_a_o = 2'b10;
                alu_op_o    = ALU_OP_W'(2'b01);
                pc_write    = zero_i ^ funct3_i[0];
                instr_done  = 1'b1;
                state_d     = StFetch;
            end
            StJal: begin
                // PC takes the target from ALUOut while the ALU forms oldPC+4 for the link.
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                pc_write    = 1'b1;
                state_d     = StAluWb;
            end
            StJalrAddr: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                state_d     = StJalrLink;
            end
            StJalrLink: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                pc_write    = 1'b1;
                state_d     = StAluWb;
            end
            StLui: begin
                // The zero on SrcA turns the U-immediate into the result.
                alu_src_a_o = 2'b11;
                alu_src_b_o = 2'b01;
                state_d     = StAluWb;
            end
            StTrap: begin
                illegal_o = 1'b1;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        imm_src_o = '0;
        case (op_i)
            OpLoad, OpI, OpJalr: imm_src_o = IMM_SRC_W'(3'b000);
            OpStore:             imm_src_o = IMM_SRC_W'(3'b001);
            OpBr:                imm_src_o = IMM_SRC_W'(3'b010);
            OpJal:               imm_src_o = IMM_SRC_W'(3'b011);
            OpLui:               imm_src_o = IMM_SRC_W'(3'b100);
            default:             imm_src_o = '0;
        endcase
    end

    // Hold every write enable low while reset is asserted, even mid-instruction.
    assign pc_write_o   = pc_write & rst_ni;
    assign mem_write_o  = mem_write & rst_ni;
    assign ir_write_o   = ir_write & rst_ni;
    assign reg_write_o  = reg_write & rst_ni;
    assign instr_done_o = instr_done & rst_ni;

`ifdef MCTRL_INSTRET_EN
    logic [31:0] instret_q;

    // Retired-instruction counter; wraps naturally at 2^32.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            instret_q <= '0;
        end else if (instr_done_o) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret_o = instret_q;
`else
    assign instret_o = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm with MEM_WAIT=2.
// Each instruction's expected per-cycle output vector is pushed to a queue when it is issued.
// The vectors are popped and compared one per cycle.
module tb_multicycle_control_fsm;

    localparam int unsigned W = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [6:0]  op_i;
    logic [2:0]  funct3_i;
    logic        zero_i;
    logic        pc_write_o, adr_src_o, mem_write_o, ir_write_o;
    logic [1:0]  result_src_o, alu_src_a_o, alu_src_b_o;
    logic [2:0]  imm_src_o;
    logic        reg_write_o;
    logic [1:0]  alu_op_o;
    logic        instr_done_o, illegal_o;
    logic [31:0] instret_o;

    always #5 clk_i = ~clk_i;

    multicycle_control_fsm #(
        .MEM_WAIT (W),
        .IMM_SRC_W(3),
        .ALU_OP_W (2)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .op_i        (op_i),
        .funct3_i    (funct3_i),
        .zero_i      (zero_i),
        .pc_write_o  (pc_write_o),
        .adr_src_o   (adr_src_o),
        .mem_write_o (mem_write_o),
        .ir_write_o  (ir_write_o),
        .result_src_o(result_src_o),
        .alu_src_a_o (alu_src_a_o),
        .alu_src_b_o (alu_src_b_o),
        .imm_src_o   (imm_src_o),
        .reg_write_o (reg_write_o),
        .alu_op_o    (alu_op_o),
        .instr_done_o(instr_done_o),
        .illegal_o   (illegal_o),
        .instret_o   (instret_o)
    );

    // {pcw, adr, mw, irw, res[1:0], a[1:0], b[1:0], imm[2:0], rw, aop[1:0], done, ill}
    logic [31:0] obs_vec;
    assign obs_vec = {14'd0, pc_write_o, adr_src_o, mem_write_o, ir_write_o, result_src_o,
                      alu_src_a_o, alu_src_b_o, imm_src_o, reg_write_o, alu_op_o,
                      instr_done_o, illegal_o};

    logic [31:0] enables;
    assign enables = {27'd0, pc_write_o, mem_write_o, ir_write_o, reg_write_o, instr_done_o};

    logic [31:0] q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_instret = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            7'b0100011: return 3'b001;
            7'b1100011: return 3'b010;
            7'b1101111: return 3'b011;
            7'b0110111: return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

    function automatic logic [31:0] rec(input logic pcw, input logic adr, input logic mw,
                                        input logic irw, input logic [1:0] res,
                                        input logic [1:0] a, input logic [1:0] b,
                                        input logic rw, input logic [1:0] aop,
                                        input logic done, input logic [2:0] im);
        return {14'd0, pcw, adr, mw, irw, res, a, b, im, rw, aop, done, 1'b0};
    endfunction

    // Expected cycles from FETCH through DECODE for the opcode currently driven.
    task automatic push_front_end(input logic [2:0] im);
        for (int i = 0; i <= int'(W); i++) begin
            q.push_back(rec(i == int'(W), 0, 0, i == int'(W), 2'b10, 2'b00, 2'b10, 0, 2'b00, 0, im));
        end
        q.push_back(rec(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 2'b00, 0, im));
    endtask

    task automatic push_instr(input logic [6:0] op, input logic [2:0] f3, input logic z);
        logic [2:0]  im;
        logic [31:0] aluwb;
        im    = imm_of(op);
        aluwb = rec(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 1, im);
        push_front_end(im);
        case (op)
            7'b0110011: begin
                q.push_back(rec(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b10, 0, im));
                q.push_back(aluwb);
            end
            7'b0010011: begin
                q.push_back(rec(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b10, 0, im));
                q.push_back(aluwb);
            end
            7'b0000011: begin
                q.push_back(rec(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 0, im));
                for (int i = 0; i <= int'(W); i++)
                    q.push_back(rec(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0, im));
                q.push_back(rec(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 2'b00, 1, im));
            end
            7'b0100011: begin
                q.push_back(rec(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 0, im));
                for (int i = 0; i <= int'(W); i++)
                    q.push_back(rec(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, i == int'(W), im));
            end
            7'b1100011: begin
                q.push_back(rec(z ^ f3[0], 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b01, 1, im));
            end
            7'b1101111: begin
                q.push_back(rec(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 2'b00, 0, im));
                q.push_back(aluwb);
            end
            7'b1100111: begin
                q.push_back(rec(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 0, im));
                q.push_back(rec(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 2'b00, 0, im));
                q.push_back(aluwb);
            end
            7'b0110111: begin
                q.push_back(rec(0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 0, 2'b00, 0, im));
                q.push_back(aluwb);
            end
            default: begin
                // Illegal opcode: TRAP cycles are pushed by the caller.
            end
        endcase
    endtask

    // Entered at a falling edge; pops one expected vector per cycle.
    task automatic run_queue(input string tag);
        logic [31:0] e;
        int          cyc;
        cyc = 0;
        while (q.size() > 0) begin
            #1;
            e = q.pop_front();
            if (e[1]) exp_instret++;
            check($sformatf("%s_c%0d", tag, cyc), obs_vec, e);
            cyc++;
            @(negedge clk_i);
        end
    endtask

    task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic z);
        op_i     = op;
        funct3_i = f3;
        zero_i   = z;
        push_instr(op, f3, z);
        run_queue(tag);
    endtask

    task automatic pulse_reset();
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni      = 1'b1;
        exp_instret = '0;
    endtask

    logic [31:0] want_instret;

    initial begin
        rst_ni   = 1'b0;
        op_i     = 7'b0110011;
        funct3_i = 3'b000;
        zero_i   = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check("reset_enables", enables, 32'd0);
        check("reset_illegal", {31'd0, illegal_o}, 32'd0);
        check("reset_instret", instret_o, 32'd0);
        rst_ni = 1'b1;

        run_instr("rtype", 7'b0110011, 3'b000, 1'b0);
        run_instr("addi", 7'b0010011, 3'b000, 1'b0);
        run_instr("lw", 7'b0000011, 3'b010, 1'b0);
        run_instr("sw", 7'b0100011, 3'b010, 1'b0);
        run_instr("beq_taken", 7'b1100011, 3'b000, 1'b1);
        run_instr("bne_nottaken", 7'b1100011, 3'b001, 1'b1);
        run_instr("beq_nottaken", 7'b1100011, 3'b000, 1'b0);
        run_instr("bne_taken", 7'b1100011, 3'b001, 1'b0);
        run_instr("jal", 7'b1101111, 3'b000, 1'b0);
        run_instr("jalr", 7'b1100111, 3'b000, 1'b0);
        run_instr("lui", 7'b0110111, 3'b000, 1'b0);

`ifdef MCTRL_INSTRET_EN
        want_instret = exp_instret;
`else
        want_instret = 32'd0;
`endif
        #1;
        check("instret_mix", instret_o, want_instret);

        // Illegal opcode traps and stays trapped with every enable low.
        op_i = 7'b1111111;
        push_front_end(3'b000);
        for (int i = 0; i < 20; i++) q.push_back(32'd1);
        run_queue("trap");
        rst_ni = 1'b0;
        #1;
        check("trap_reset_enables", enables, 32'd0);
        @(negedge clk_i);
        rst_ni      = 1'b1;
        exp_instret = '0;
        #1;
        check("trap_cleared", {31'd0, illegal_o}, 32'd0);
        run_instr("after_trap", 7'b0110011, 3'b000, 1'b0);

        // Reset in the first MEMWRITE cycle must drop the write and restart at FETCH.
        op_i = 7'b0100011;
        push_instr(7'b0100011, 3'b010, 1'b0);
        for (int i = 0; i <= int'(W); i++) void'(q.pop_back());
        run_queue("sw_abort");
        #1;
        check("sw_abort_pre_mw", {31'd0, mem_write_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check("sw_abort_mw_low", {31'd0, mem_write_o}, 32'd0);
        check("sw_abort_enables", enables, 32'd0);
        @(negedge clk_i);
        rst_ni      = 1'b1;
        exp_instret = '0;
        run_instr("after_abort", 7'b0110011, 3'b000, 1'b0);

        // Ten back-to-back R-types from a clean reset.
        pulse_reset();
        for (int i = 0; i < 10; i++) run_instr($sformatf("r10_%0d", i), 7'b0110011, 3'b000, 1'b0);
`ifdef MCTRL_INSTRET_EN
        want_instret = 32'd10;
`else
        want_instret = 32'd0;
`endif
        #1;
        check("instret_10", instret_o, want_instret);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
